// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX path (and a future RX path).
// Exports DEFAULT_DIV, the nominal divisor for the documented clock and baud.
package uart_pkg;

    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int unsigned default_div(input int unsigned clk_freq, input int unsigned baud);
        return (baud == 32'd0) ? 32'd0 : clk_freq / baud;
    endfunction

    localparam int unsigned DEFAULT_DIV = default_div(32'd100_000_000, 32'd115_200);

    // Payload is zero-extended to 9 bits so every supported width shares one helper.
    function automatic logic parity_bit(input logic [8:0] payload, input logic odd);
        return (^payload) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Producer-side byte stream handshake: a write happens when valid && ready.
interface uart_tx_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           level_q, level_d;
    logic                  full_q, empty_q;
    logic                  do_wr_s, do_rd_s;

    assign do_wr_s = wr_en && !full_q;
    assign do_rd_s = rd_en && !empty_q;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (do_wr_s && !do_rd_s) begin
            level_d = level_q + LVL_ONE;
        end else if (!do_wr_s && do_rd_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Pointers, occupancy and flags; flags are registered from the next level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_wr_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q <= level_d;
            full_q  <= (level_d == LVL_FULL);
            empty_q <= (level_d == {(AW+1){1'b0}});
        end
    end

    // Storage array; no reset needed since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr_s) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmitter fed by a TX FIFO; divisor, stop bits and parity are latched per frame.
// Optional parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_fifo_ctrl_if.slave          tx_if,
    input  logic [DIV_WIDTH-1:0]        div,
    input  logic                        stop2,
    input  logic [1:0]                  parity_mode,
    output logic                        sig,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam int unsigned unused_nominal_div = default_div(CLK_FREQ, BAUD_RATE);

    tx_state_e             state_q;
    logic                  sig_q, busy_q, stop2_q, stop_left_q;
    logic [DIV_WIDTH-1:0]  div_q, cnt_q, div_c_s;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] sh_q, head_s;
    logic                  full_s, empty_s, push_s, pop_s, frame_end_s;

    assign push_s = tx_if.valid && !full_s;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_s),
        .wr_data (tx_if.data),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_bit_q;
`else
    logic unused_parity_s;
    assign unused_parity_s = ^parity_mode;
`endif

    // Clamp the divisor and decide whether this edge starts a new frame.
    always_comb begin
        div_c_s     = div;
        frame_end_s = 1'b0;
        pop_s       = 1'b0;
        if (div < DIV_MIN) begin
            div_c_s = DIV_MIN;
        end else begin
            div_c_s = div;
        end
        if ((state_q == ST_STOP) && (cnt_q == DIV_ZERO) && !stop_left_q) begin
            frame_end_s = 1'b1;
        end else begin
            frame_end_s = 1'b0;
        end
        if (!empty_s && ((state_q == ST_IDLE) || frame_end_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sig_q       <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= DIV_ZERO;
            div_q       <= DIV_MIN;
            idx_q       <= {IDX_W{1'b0}};
            sh_q        <= {DATA_WIDTH{1'b0}};
            stop2_q     <= 1'b0;
            stop_left_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
`endif
        end else if (pop_s) begin
            state_q     <= ST_START;
            sig_q       <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= div_c_s - DIV_ONE;
            div_q       <= div_c_s;
            sh_q        <= head_s;
            stop2_q     <= stop2;
            stop_left_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q    <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit_q   <= parity_bit(9'(head_s), parity_mode == PAR_ODD);
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sig_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_START: begin
                    if (cnt_q == DIV_ZERO) begin
                        state_q <= ST_DATA;
                        sig_q   <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                        idx_q   <= {IDX_W{1'b0}};
                        cnt_q   <= div_q - DIV_ONE;
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != DIV_ZERO) begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end else if (idx_q != IDX_LAST) begin
                        idx_q <= idx_q + IDX_ONE;
                        sig_q <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                        cnt_q <= div_q - DIV_ONE;
`ifdef UART_TX_PARITY_EN
                    end else if (par_en_q) begin
                        state_q <= ST_PARITY;
                        sig_q   <= par_bit_q;
                        cnt_q   <= div_q - DIV_ONE;
`endif
                    end else begin
                        state_q     <= ST_STOP;
                        sig_q       <= 1'b1;
                        stop_left_q <= stop2_q;
                        cnt_q       <= div_q - DIV_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == DIV_ZERO) begin
                        state_q     <= ST_STOP;
                        sig_q       <= 1'b1;
                        stop_left_q <= stop2_q;
                        cnt_q       <= div_q - DIV_ONE;
                    end else begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q != DIV_ZERO) begin
                        cnt_q <= cnt_q - DIV_ONE;
                    end else if (stop_left_q) begin
                        stop_left_q <= 1'b0;
                        cnt_q       <= div_q - DIV_ONE;
                    end else begin
                        state_q <= ST_IDLE;
                        sig_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sig_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.ready = !full_s;
    assign sig         = sig_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Randomised self-checking bench: a waveform-list model predicts sig/busy/level/ready every cycle.
module tb_uart_tx_fifo_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [DIVW-1:0] div   = 16'd4;
    logic            stop2 = 1'b0;
    logic [1:0]      pm    = 2'b00;
    logic            sig, busy;
    logic [2:0]      fifo_level;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model: queued bytes plus the per-cycle line values of the frame in flight.
    logic [7:0] mq[$];
    bit         mw[$];
    logic       m_sig = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_pushed = 1'b0;
    int         m_level = 0;

    uart_tx_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus();

    uart_tx_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_if       (bus),
        .div         (div),
        .stop2       (stop2),
        .parity_mode (pm),
        .sig         (sig),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic void build_frame(input logic [7:0] b, input int unsigned dv, input bit s2, input logic [1:0] p);
        int unsigned d;
        bit bits[$];
        d = (dv < 2) ? 2 : dv;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(b[i]);
        if (PAR_ON && p == 2'b01) bits.push_back(^b);
        else if (PAR_ON && p == 2'b10) bits.push_back(~(^b));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) for (int j = 0; j < d; j++) mw.push_back(bits[k]);
    endfunction

    // One clock: apply the edge to the model, then return at the falling edge for sampling.
    task automatic tick();
        bit push;
        logic [7:0] d;
        int unsigned dv;
        bit s2;
        logic [1:0] p;
        push = bus.valid && m_ready;
        d = bus.data; dv = div; s2 = stop2; p = pm;
        @(posedge clk);
        if (!rst_n) begin
            mw.delete(); mq.delete(); push = 1'b0;
        end else begin
            if (mw.size() != 0) void'(mw.pop_front());
            if (mw.size() == 0 && mq.size() != 0) build_frame(mq.pop_front(), dv, s2, p);
            if (push) mq.push_back(d);
        end
        m_pushed = push;
        m_sig    = (mw.size() != 0) ? mw[0] : 1'b1;
        m_busy   = (mw.size() != 0);
        m_level  = mq.size();
        m_ready  = (m_level != DEPTH);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.valid = 1'b0; bus.data = 8'h00;
        repeat (3) tick();
        cmp_cnt++;
        if ({sig, busy, fifo_level, bus.ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset_state: sig/busy/level/ready got %b/%b/%0d/%b want 1/0/0/1", sig, busy, fifo_level, bus.ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                err_cnt++;
                $display("FAIL reset_release cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
            end
        end
    endtask

    task automatic test_single_frame();
        int bc = 0;
        div = 16'd4; pm = 2'b00; stop2 = 1'b0;
        bus.data = 8'hA5; bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy) bc++;
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                err_cnt++;
                $display("FAIL single_frame cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
            end
            if (i == 0) begin
                cmp_cnt++;
                if (sig !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL start_latency: sig got %b want 0", sig);
                end
            end
        end
        cmp_cnt++;
        if (bc != 40) begin
            err_cnt++;
            $display("FAIL single_busy_len: got %0d want 40", bc);
        end
    endtask

    task automatic test_parity();
        for (int m = 0; m < 2; m++) begin
            int bc = 0;
            logic exp_par;
            exp_par = PAR_ON ? ((m == 0) ? 1'b1 : 1'b0) : 1'b1;
            div = 16'd4; stop2 = 1'b0; pm = (m == 0) ? 2'b01 : 2'b10;
            bus.data = 8'h07; bus.valid = 1'b1;
            tick();
            bus.valid = 1'b0;
            for (int i = 0; i < 56; i++) begin
                tick();
                if (busy) bc++;
                cmp_cnt++;
                if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                    err_cnt++;
                    $display("FAIL parity%0d cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", m, i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
                end
                if (i == 37) begin
                    cmp_cnt++;
                    if (sig !== exp_par) begin
                        err_cnt++;
                        $display("FAIL parity_bit%0d: got %b want %b", m, sig, exp_par);
                    end
                end
            end
            cmp_cnt++;
            if (bc != (PAR_ON ? 44 : 40)) begin
                err_cnt++;
                $display("FAIL parity_len%0d: got %0d want %0d", m, bc, PAR_ON ? 44 : 40);
            end
        end
        pm = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[6];
        int idx = 0;
        int bc = 0;
        for (int k = 0; k < 6; k++) b[k] = 8'(k * 41 + $urandom_range(0, 40));
        div = 16'd2; pm = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 140; i++) begin
            bus.valid = (idx < 6);
            bus.data  = (idx < 6) ? b[idx] : 8'h00;
            tick();
            if (m_pushed) idx++;
            if (busy) bc++;
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                err_cnt++;
                $display("FAIL b2b cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
            end
            if (i == 7) begin
                cmp_cnt++;
                if (idx != 5 || bus.ready !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL b2b_fill: accepted %0d ready %b want 5 and 0", idx, bus.ready);
                end
            end
        end
        bus.valid = 1'b0;
        cmp_cnt++;
        if (bc != 120) begin
            err_cnt++;
            $display("FAIL b2b_busy_len: got %0d want 120", bc);
        end
    endtask

    task automatic test_stop2();
        int bc = 0;
        div = 16'd3; pm = 2'b00; stop2 = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bus.valid = (i < 2);
            bus.data  = (i == 0) ? 8'hFF : 8'h00;
            tick();
            if (busy) bc++;
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                err_cnt++;
                $display("FAIL stop2 cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
            end
        end
        bus.valid = 1'b0; stop2 = 1'b0;
        cmp_cnt++;
        if (bc != 66) begin
            err_cnt++;
            $display("FAIL stop2_busy_len: got %0d want 66", bc);
        end
    endtask

    task automatic test_div_change();
        int bc = 0;
        div = 16'd0; pm = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.valid = (i == 0);
            bus.data  = 8'($urandom);
            tick();
            if (busy) bc++;
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                err_cnt++;
                $display("FAIL div0 cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
            end
        end
        cmp_cnt++;
        if (bc != 20) begin
            err_cnt++;
            $display("FAIL div0_busy_len: got %0d want 20", bc);
        end
        bc = 0;
        div = 16'd4;
        for (int i = 0; i < 140; i++) begin
            bus.valid = (i < 2);
            bus.data  = 8'($urandom);
            if (i == 10) div = 16'd8;
            tick();
            if (busy) bc++;
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                err_cnt++;
                $display("FAIL div_change cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
            end
        end
        bus.valid = 1'b0;
        cmp_cnt++;
        if (bc != 120) begin
            err_cnt++;
            $display("FAIL div_change_busy_len: got %0d want 120", bc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            bus.valid = (i < 400) && ($urandom_range(0, 3) == 0);
            bus.data  = 8'($urandom);
            div       = 16'($urandom_range(0, 5));
            stop2     = 1'($urandom_range(0, 1));
            pm        = 2'($urandom_range(0, 3));
            tick();
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready}) begin
                err_cnt++;
                $display("FAIL random cyc%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
            end
        end
        bus.valid = 1'b0; pm = 2'b00; stop2 = 1'b0;
    endtask

    task automatic test_reset_midframe();
        div = 16'd4; pm = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid = 1'b1;
            bus.data  = 8'($urandom);
            tick();
        end
        bus.valid = 1'b0;
        repeat (16) tick();
        cmp_cnt++;
        if ({sig, busy, fifo_level, bus.ready} !== {m_sig, m_busy, 3'(m_level), m_ready} || m_level != 2) begin
            err_cnt++;
            $display("FAIL pre_reset: got %b/%b/%0d/%b want %b/%b/%0d/%b level 2", sig, busy, fifo_level, bus.ready, m_sig, m_busy, m_level, m_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); mw.delete();
        m_sig = 1'b1; m_busy = 1'b0; m_level = 0; m_ready = 1'b1;
        cmp_cnt++;
        if ({sig, busy, fifo_level, bus.ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL async_reset: got %b/%b/%0d/%b want 1/0/0/1", sig, busy, fifo_level, bus.ready);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            cmp_cnt++;
            if ({sig, busy, fifo_level, bus.ready} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
                err_cnt++;
                $display("FAIL post_reset_idle cyc%0d: got %b/%b/%0d/%b want 1/0/0/1", i, sig, busy, fifo_level, bus.ready);
            end
        end
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_stop2();
        test_div_change();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
